// File: rtl/instr_fetch.sv
// IF stage of the RV32I pipeline: owns the PC, fetches one word at a time from
// instruction memory and holds the IF/ID register consumed by the decoder.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        FULL
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] req_addr;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic        drop;

    logic        accept;
    logic        resp;
    logic        load_resp;
    logic        load_skid;
    logic [31:0] target_pc;
    logic [31:0] next_pc;

    // req_addr is separate from fetch_pc so a redirect cannot disturb a request
    // that is already being presented and still waits for imem_ready.
    assign imem_addr = req_addr;
    assign accept    = imem_req && imem_ready;
    assign resp      = (state == WAIT) && imem_rvalid;
    assign load_resp = resp && !drop && (!if_valid || !stall);
    assign load_skid = (state == FULL) && !stall;
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    assign next_pc   = fetch_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= REQ;
            fetch_pc   <= RESET_PC;
            req_addr   <= RESET_PC;
            imem_req   <= 1'b0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= 32'd0;
            drop       <= 1'b0;
            if_instr   <= NOP_INSTR;
            if_pc      <= 32'd0;
            if_valid   <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= target_pc;
                case (state)
                    REQ: begin
                        if (!imem_req) begin
                            imem_req <= 1'b1;
                            req_addr <= target_pc;
                        end else if (accept) begin
                            state    <= WAIT;
                            imem_req <= 1'b0;
                            drop     <= 1'b1;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                            req_addr <= target_pc;
                            drop     <= 1'b0;
                        end else begin
                            drop <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        req_addr <= target_pc;
                    end
                endcase
            end else begin
                case (state)
                    REQ: begin
                        if (accept) begin
                            state    <= WAIT;
                            imem_req <= 1'b0;
                        end else begin
                            imem_req <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid) begin
                            if (drop) begin
                                drop     <= 1'b0;
                                state    <= REQ;
                                imem_req <= 1'b1;
                                req_addr <= fetch_pc;
                            end else begin
                                fetch_pc <= next_pc;
                                if (load_resp) begin
                                    state    <= REQ;
                                    imem_req <= 1'b1;
                                    req_addr <= next_pc;
                                end else begin
                                    skid_instr <= imem_rdata;
                                    skid_pc    <= fetch_pc;
                                    state      <= FULL;
                                end
                            end
                        end
                    end
                    FULL: begin
                        if (!stall) begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                            req_addr <= fetch_pc;
                        end
                    end
                    default: begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                        req_addr <= fetch_pc;
                    end
                endcase
            end

            // IF/ID register: flush beats fresh data, which beats the skid entry.
            if (redirect) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end else if (load_resp) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= fetch_pc;
            end else if (load_skid) begin
                if_valid <= 1'b1;
                if_instr <= skid_instr;
                if_pc    <= skid_pc;
            end else if (!stall) begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a program-order PC model checks the IF/ID register every
// cycle while directed scenarios pin the exact fetch timing and addresses.
module tb_instr_fetch;

    localparam logic [31:0] NOP           = 32'h0000_0013;
    localparam logic [31:0] MAIN_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        ready_en = 1'b1;

    logic        w_req;
    logic [31:0] w_addr;
    logic        w_rvalid = 1'b0;
    logic [31:0] w_rdata = 32'd0;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_valid;
    logic        w_cap = 1'b0;
    logic [31:0] w_cap_addr = 32'd0;
    logic [31:0] w_acc_q[$];
    logic [31:0] w_pc_q[$];
    logic [31:0] w_ins_q[$];

    int          compared = 0;
    int          mismatched = 0;

    int          mem_lat = 1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'd0;
    int          wait_cnt = 0;
    int          acc_cnt = 0;
    logic [31:0] last_acc = 32'd0;

    logic [31:0] model_pc = MAIN_RESET_PC;
    logic        p_valid = 1'b0;
    logic        p_stall = 1'b0;
    logic        p_redirect = 1'b0;
    logic [31:0] p_target = 32'd0;
    logic        p_req = 1'b0;
    logic        p_ready = 1'b0;
    logic [31:0] p_addr = 32'd0;

    assign imem_ready = ready_en;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(MAIN_RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid)
    );

    instr_fetch #(.RESET_PC(WRAP_RESET_PC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'd0),
        .if_instr(w_instr), .if_pc(w_pc), .if_valid(w_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0000_0013;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_accept(input string name, input logic [31:0] exp_addr);
        int   start;
        logic got;
        start = acc_cnt;
        got   = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (acc_cnt != start) got = 1'b1;
        end
        checkOutput({name, "_seen"}, {31'd0, got}, 32'd1);
        if (got) checkOutput(name, last_acc, exp_addr);
    endtask

    task automatic wait_valid_pc(input string name, input logic [31:0] pc, input logic [31:0] instr);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (if_valid && if_pc == pc) got = 1'b1;
        end
        checkOutput({name, "_seen"}, {31'd0, got}, 32'd1);
        if (got) checkOutput({name, "_instr"}, if_instr, instr);
    endtask

    // Instruction memory: contents are addr^0x13, response mem_lat cycles after accept.
    always @(posedge clk) begin
        if (rst_n && imem_req && imem_ready) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            wait_cnt  = mem_lat;
            acc_cnt++;
            last_acc  = imem_addr;
        end
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (pend) begin
            if (wait_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
                pend        = 1'b0;
            end else begin
                wait_cnt--;
            end
        end
    end

    always @(posedge clk) begin
        w_cap = 1'b0;
        if (rst_n && w_req) begin
            w_cap      = 1'b1;
            w_cap_addr = w_addr;
            w_acc_q.push_back(w_addr);
        end
        #1;
        w_rvalid = w_cap;
        w_rdata  = mem_word(w_cap_addr);
    end

    always @(negedge clk) begin
        if (rst_n && w_valid) begin
            w_pc_q.push_back(w_pc);
            w_ins_q.push_back(w_instr);
        end
    end

    // Program-order model: the next instruction the decoder may see is model_pc.
    always @(negedge clk) begin
        if (!rst_n) begin
            model_pc   = MAIN_RESET_PC;
            p_valid    = 1'b0;
            p_stall    = 1'b0;
            p_redirect = 1'b0;
            p_req      = 1'b0;
            p_ready    = 1'b0;
            checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
            checkOutput("rst_if_instr", if_instr, NOP);
            checkOutput("rst_if_pc", if_pc, 32'd0);
            checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
        end else begin
            if (p_redirect) begin
                model_pc = p_target & 32'hFFFF_FFFC;
                checkOutput("flush_valid", {31'd0, if_valid}, 32'd0);
            end else if (p_valid && !p_stall) begin
                model_pc = model_pc + 32'd4;
            end else if (p_valid && p_stall) begin
                checkOutput("stall_hold_valid", {31'd0, if_valid}, 32'd1);
            end
            if (if_valid) begin
                checkOutput("model_if_pc", if_pc, model_pc);
                checkOutput("model_if_instr", if_instr, mem_word(model_pc));
            end else begin
                checkOutput("bubble_instr", if_instr, NOP);
            end
            if (imem_req) checkOutput("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (p_req && !p_ready) begin
                checkOutput("req_held", {31'd0, imem_req}, 32'd1);
                checkOutput("addr_stable", imem_addr, p_addr);
            end
            p_valid    = if_valid;
            p_stall    = stall;
            p_redirect = redirect;
            p_target   = redirect_pc;
            p_req      = imem_req;
            p_ready    = imem_ready;
            p_addr     = imem_addr;
        end
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 32'd0);
        repeat (3) step();
        checkOutput("reset_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("reset_instr", if_instr, NOP);
        checkOutput("reset_req", {31'd0, imem_req}, 32'd0);

        // Sequential fetch at 1-cycle memory latency
        rst_n = 1'b1;
        step();
        checkOutput("a_req_e1", {31'd0, imem_req}, 32'd1);
        checkOutput("a_addr_e1", imem_addr, 32'h0);
        step();
        checkOutput("a_req_wait", {31'd0, imem_req}, 32'd0);
        step();
        checkOutput("a_valid0", {31'd0, if_valid}, 32'd1);
        checkOutput("a_pc0", if_pc, 32'h0);
        checkOutput("a_instr0", if_instr, 32'h13);
        checkOutput("a_addr4", imem_addr, 32'h4);
        step();
        checkOutput("a_bubble", {31'd0, if_valid}, 32'd0);
        checkOutput("a_bubble_instr", if_instr, NOP);
        step();
        checkOutput("a_valid1", {31'd0, if_valid}, 32'd1);
        checkOutput("a_pc1", if_pc, 32'h4);
        checkOutput("a_instr1", if_instr, 32'h17);

        // Stall for five cycles: pc 8 parks in the skid
        applyStimulus(1'b1, 1'b0, 32'd0);
        step();
        step();
        checkOutput("b_full_req", {31'd0, imem_req}, 32'd0);
        checkOutput("b_hold_pc", if_pc, 32'h4);
        repeat (3) step();
        checkOutput("b_hold_pc_end", if_pc, 32'h4);
        checkOutput("b_hold_valid", {31'd0, if_valid}, 32'd1);
        checkOutput("b_full_req_end", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0);
        step();
        checkOutput("b_skid_valid", {31'd0, if_valid}, 32'd1);
        checkOutput("b_skid_pc", if_pc, 32'h8);
        checkOutput("b_skid_instr", if_instr, 32'h1B);
        checkOutput("b_next_req", {31'd0, imem_req}, 32'd1);
        checkOutput("b_next_addr", imem_addr, 32'hC);

        // Redirect while a 3-cycle read is outstanding
        mem_lat = 3;
        wait_accept("c_acc_c", 32'hC);
        applyStimulus(1'b0, 1'b1, 32'h100);
        mem_lat = 1;
        step();
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("c_flush_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("c_req_during_drop", {31'd0, imem_req}, 32'd0);
        wait_accept("c_acc_target", 32'h100);
        wait_valid_pc("c_target", 32'h100, 32'h113);

        // Redirect in the same cycle as rvalid, unaligned target
        wait_accept("d_acc_104", 32'h104);
        applyStimulus(1'b0, 1'b1, 32'h203);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("d_flush_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("d_req", {31'd0, imem_req}, 32'd1);
        checkOutput("d_addr", imem_addr, 32'h200);
        wait_accept("d_acc_200", 32'h200);
        wait_valid_pc("d_target", 32'h200, 32'h213);

        // imem_ready low for four cycles, redirect while the request waits
        ready_en = 1'b0;
        checkOutput("e_addr0", imem_addr, 32'h204);
        step();
        checkOutput("e_addr1", imem_addr, 32'h204);
        step();
        applyStimulus(1'b0, 1'b1, 32'h300);
        step();
        applyStimulus(1'b0, 1'b0, 32'd0);
        checkOutput("e_addr_after_redirect", imem_addr, 32'h204);
        checkOutput("e_req_after_redirect", {31'd0, imem_req}, 32'd1);
        step();
        checkOutput("e_addr3", imem_addr, 32'h204);
        ready_en = 1'b1;
        wait_accept("e_acc_old", 32'h204);
        wait_accept("e_acc_target", 32'h300);
        wait_valid_pc("e_target", 32'h300, 32'h313);

        // Reset asserted while a read is outstanding; its late rvalid must be ignored
        mem_lat = 3;
        wait_accept("f_acc", 32'h304);
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("f_rst_valid", {31'd0, if_valid}, 32'd0);
        checkOutput("f_rst_instr", if_instr, NOP);
        checkOutput("f_rst_pc", if_pc, 32'd0);
        checkOutput("f_rst_req", {31'd0, imem_req}, 32'd0);
        step();
        rst_n   = 1'b1;
        mem_lat = 1;
        wait_valid_pc("f_post_reset", 32'h0, 32'h13);
        repeat (4) step();

        // PC wrap on the second instance
        checkOutput("w_acc_count", {31'd0, w_acc_q.size() >= 2}, 32'd1);
        if (w_acc_q.size() >= 2) begin
            checkOutput("w_acc0", w_acc_q[0], 32'hFFFF_FFFC);
            checkOutput("w_acc1", w_acc_q[1], 32'h0000_0000);
        end
        checkOutput("w_del_count", {31'd0, w_pc_q.size() >= 2}, 32'd1);
        if (w_pc_q.size() >= 2) begin
            checkOutput("w_pc0", w_pc_q[0], 32'hFFFF_FFFC);
            checkOutput("w_instr0", w_ins_q[0], 32'hFFFF_FFEF);
            checkOutput("w_pc1", w_pc_q[1], 32'h0000_0000);
            checkOutput("w_instr1", w_ins_q[1], 32'h0000_0013);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
